// File: rtl/alu32_pkg.sv
// Shared constants and state type for the sequential divider and its alu32 partner.
`timescale 1ns/1ps
package alu32_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 5;

   // alu32 control encodings used to request A - B
   localparam logic [3:0] SUB_SEL_ENC       = 4'b0110;
   localparam logic       SUB_MODE_ENC      = 1'b0;
   localparam logic       SUB_CIN_ENC       = 1'b1;
   // Cout level meaning the subtraction did not borrow (trial >= divisor)
   localparam logic       NOBORROW_COUT_ENC = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/alu32_div_seq.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per cycle.
// The trial subtraction is done by an external alu32; operands to it come
// straight from registers, and its result/Cout come back in the same cycle.
`timescale 1ns/1ps
module alu32_div_seq
   import alu32_pkg::*;
#(
   parameter logic [3:0] SUB_SEL       = SUB_SEL_ENC,
   parameter logic       SUB_MODE      = SUB_MODE_ENC,
   parameter logic       SUB_CIN       = SUB_CIN_ENC,
   parameter logic       NOBORROW_COUT = NOBORROW_COUT_ENC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             dbz,
   output logic             busy,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic             alu_mode,
   output logic [3:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout
);

   div_state_e       state_q;
   logic [WIDTH-1:0] r_q, q_q, d_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quot_q, rem_q;
   logic             dbz_q;

   logic [WIDTH-1:0] trial;
   logic             take;
   logic [WIDTH-1:0] r_d, q_d;

   // Restoring step: shift next dividend bit into R, subtract D when it fits.
   // R[31] set means the shifted trial exceeds 2^32 > D, so it always fits.
   assign trial = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign take  = r_q[WIDTH-1] | (alu_cout == NOBORROW_COUT);
   assign r_d   = take ? alu_result : trial;
   assign q_d   = {q_q[WIDTH-2:0], take};

   assign alu_a    = trial;
   assign alu_b    = d_q;
   assign alu_sel  = SUB_SEL;
   assign alu_mode = SUB_MODE;
   assign alu_cin  = SUB_CIN;

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign dbz       = dbz_q;

   // Control FSM and datapath registers: accept, 32 divide steps, hold result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  d_q   <= divisor;
                  q_q   <= dividend;
                  r_q   <= '0;
                  cnt_q <= '0;
                  if (divisor == '0) begin
                     quot_q  <= '1;
                     rem_q   <= dividend;
                     dbz_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  quot_q  <= q_d;
                  rem_q   <= r_d;
                  dbz_q   <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu32_div_seq.sv
// Self-checking bench for alu32_div_seq with a behavioural alu32 alongside it.
`timescale 1ns/1ps
module tb_alu32_div_seq;

   localparam int N_RANDOM = 1500;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        dbz;
   logic        busy;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_cin;
   logic        alu_mode;
   logic [3:0]  alu_sel;
   logic [31:0] alu_result;
   logic        alu_cout;

   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   alu32_div_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .dbz        (dbz),
      .busy       (busy),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_mode   (alu_mode),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .alu_cout   (alu_cout)
   );

   // Behavioural alu32: only the subtract encoding yields a meaningful result
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum = '0;
      if (alu_sel == 4'b0110 && alu_mode == 1'b0)
         alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {32'd0, alu_cin};
   end
   assign alu_result = alu_sum[31:0];
   assign alu_cout   = alu_sum[32];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [31:0] dvd, input logic [31:0] dvs);
      exp_t e;
      e.dvd = dvd;
      e.dvs = dvs;
      if (dvs == 32'd0) begin
         e.q   = 32'hFFFF_FFFF;
         e.r   = dvd;
         e.dbz = 1'b1;
      end else begin
         e.q   = dvd / dvs;
         e.r   = dvd % dvs;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'd0;
         1:       v = 32'($urandom_range(1, 15));
         2:       v = $urandom | 32'h8000_0000;
         3:       v = 32'hFFFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Waits (bounded) for in_ready, presents one request, pushes its expectation.
   task automatic accept_op(input logic [31:0] dvd, input logic [31:0] dvs);
      int waitc = 0;
      while (in_ready !== 1'b1 && waitc < 100) begin
         @(posedge clk); #1;
         waitc++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL accept_wait in_ready=%b required=1", in_ready);
      end
      dividend = dvd;
      divisor  = dvs;
      in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(model(dvd, dvs));
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Edges counted from the accepting edge (inclusive) until out_valid is seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (quotient !== 32'd0) begin bad++; $display("FAIL rst_quotient got=%h exp=0", quotient); end
      total++; if (remainder !== 32'd0) begin bad++; $display("FAIL rst_remainder got=%h exp=0", remainder); end
      total++; if (dbz !== 1'b0) begin bad++; $display("FAIL rst_dbz got=%b exp=0", dbz); end
      total++; if (alu_b !== 32'd0) begin bad++; $display("FAIL rst_alu_b got=%h exp=0", alu_b); end
      total++; if (alu_sel !== 4'b0110) begin bad++; $display("FAIL alu_sel got=%b exp=0110", alu_sel); end
      total++; if (alu_mode !== 1'b0) begin bad++; $display("FAIL alu_mode got=%b exp=0", alu_mode); end
      total++; if (alu_cin !== 1'b1) begin bad++; $display("FAIL alu_cin got=%b exp=1", alu_cin); end
      rst_n = 1'b1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      exp_t e;
      int   lat;
      accept_op(32'd100, 32'd7);
      wait_valid(lat);
      e = sb.pop_front();
      total++; if (lat != 33) begin bad++; $display("FAIL basic_latency got=%0d exp=33", lat); end
      total++; if (quotient !== e.q) begin bad++; $display("FAIL basic_quotient got=%0d exp=%0d", quotient, e.q); end
      total++; if (remainder !== e.r) begin bad++; $display("FAIL basic_remainder got=%0d exp=%0d", remainder, e.r); end
      total++; if (dbz !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", dbz); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_done got=%b exp=0", in_ready); end
      handshake();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle got=%b exp=1", in_ready); end
   endtask

   task automatic test_rtake();
      exp_t e;
      int   lat;
      accept_op(32'hFFFF_FFFF, 32'h8000_0001);
      wait_valid(lat);
      e = sb.pop_front();
      total++; if (lat != 33) begin bad++; $display("FAIL rtake_latency got=%0d exp=33", lat); end
      total++; if (quotient !== e.q) begin bad++; $display("FAIL rtake_quotient got=%h exp=%h", quotient, e.q); end
      total++; if (remainder !== e.r) begin bad++; $display("FAIL rtake_remainder got=%h exp=%h", remainder, e.r); end
      total++; if (dbz !== 1'b0) begin bad++; $display("FAIL rtake_dbz got=%b exp=0", dbz); end
      handshake();
   endtask

   task automatic test_dbz();
      exp_t e;
      int   lat;
      accept_op(32'h1234_5678, 32'd0);
      wait_valid(lat);
      e = sb.pop_front();
      total++; if (lat != 1) begin bad++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
      total++; if (quotient !== e.q) begin bad++; $display("FAIL dbz_quotient got=%h exp=%h", quotient, e.q); end
      total++; if (remainder !== e.r) begin bad++; $display("FAIL dbz_remainder got=%h exp=%h", remainder, e.r); end
      total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", dbz); end
      handshake();
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      accept_op(32'hFFFF_FFFF, 32'd1);
      wait_valid(lat);
      e = sb.pop_front();
      total++; if (lat != 33) begin bad++; $display("FAIL bp_latency got=%0d exp=33", lat); end
      // Noise on the request side must not disturb the held result
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
         total++; if (quotient !== e.q) begin bad++; $display("FAIL bp_quotient cyc=%0d got=%h exp=%h", i, quotient, e.q); end
         total++; if (remainder !== e.r) begin bad++; $display("FAIL bp_remainder cyc=%0d got=%h exp=%h", i, remainder, e.r); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
         dividend = $urandom;
         divisor  = $urandom;
         @(posedge clk); #1;
      end
      handshake();
      in_valid = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_after got=%b exp=0", busy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_out_valid_after got=%b exp=0", out_valid); end
      total++; if (quotient !== e.q) begin bad++; $display("FAIL bp_quotient_hold got=%h exp=%h", quotient, e.q); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   lat;
      bit   ov_seen = 1'b0;
      accept_op(32'hDEAD_BEEF, 32'h0000_1234);
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) ov_seen = 1'b1;
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      total++; if (quotient !== 32'd0) begin bad++; $display("FAIL rmid_quotient got=%h exp=0", quotient); end
      total++; if (remainder !== 32'd0) begin bad++; $display("FAIL rmid_remainder got=%h exp=0", remainder); end
      total++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin bad++; $display("FAIL rmid_regs alu_a=%h alu_b=%h exp=0", alu_a, alu_b); end
      // The aborted request never produces a result
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) begin
         if (out_valid !== 1'b0) ov_seen = 1'b1;
         @(posedge clk); #1;
      end
      total++; if (ov_seen) begin bad++; $display("FAIL rmid_out_valid got=1 exp=0"); end
      accept_op(32'd9, 32'd3);
      wait_valid(lat);
      e = sb.pop_front();
      total++; if (lat != 33) begin bad++; $display("FAIL rmid_latency got=%0d exp=33", lat); end
      total++; if (quotient !== e.q) begin bad++; $display("FAIL rmid_9div3_q got=%0d exp=%0d", quotient, e.q); end
      total++; if (remainder !== e.r) begin bad++; $display("FAIL rmid_9div3_r got=%0d exp=%0d", remainder, e.r); end
      handshake();
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      int          accepted = 0;
      int          done     = 0;
      int          cyc      = 0;
      logic [63:0] recon;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      dividend  = rand_op();
      divisor   = rand_op();
      while (done < N_RANDOM && cyc < N_RANDOM * 40) begin
         if (out_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL b2b_unexpected_result q=%h r=%h", quotient, remainder);
            end else begin
               e = sb.pop_front();
               total++; if (quotient !== e.q) begin bad++; $display("FAIL b2b_quotient %h/%h got=%h exp=%h", e.dvd, e.dvs, quotient, e.q); end
               total++; if (remainder !== e.r) begin bad++; $display("FAIL b2b_remainder %h/%h got=%h exp=%h", e.dvd, e.dvs, remainder, e.r); end
               total++; if (dbz !== e.dbz) begin bad++; $display("FAIL b2b_dbz %h/%h got=%b exp=%b", e.dvd, e.dvs, dbz, e.dbz); end
               if (e.dvs != 32'd0) begin
                  recon = 64'(quotient) * 64'(e.dvs) + 64'(remainder);
                  total++; if (recon !== 64'(e.dvd)) begin bad++; $display("FAIL b2b_identity got=%h exp=%h", recon, 64'(e.dvd)); end
                  total++; if (remainder >= e.dvs) begin bad++; $display("FAIL b2b_rem_bound got=%h exp<%h", remainder, e.dvs); end
               end
            end
            done++;
         end
         total++;
         if (in_ready === 1'b1 && out_valid === 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_overlap in_ready=1 out_valid=1 exp=exclusive");
         end
         if (in_ready === 1'b1 && in_valid === 1'b1) begin
            sb.push_back(model(dividend, divisor));
            accepted++;
         end
         @(posedge clk); #1;
         cyc++;
         in_valid = (accepted < N_RANDOM);
         dividend = rand_op();
         divisor  = rand_op();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      total++; if (done != N_RANDOM) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", done, N_RANDOM); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rtake();
      test_dbz();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
